// File: rtl/fifo_to_axis_pkt_tx.sv
// FWFT packet FIFO to AXI-Stream transmitter: decodes the length from the header beat and streams the packet through a registered AXIS output stage.
// Optional length check / drop path is enabled by defining FIFO_TO_AXIS_LEN_CHECK_EN.
module fifo_to_axis_pkt_tx #(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = $clog2(DATA_WIDTH/8),
    parameter int LEN_LSB    = 48,
    parameter int LEN_MSB    = 58,
    parameter int USER_WIDTH = 7,
    parameter int MAX_LEN4   = 1100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  o_fifo_rd_en,
    input  logic                  i_fifo_empty,
    input  logic [DATA_WIDTH-1:0] iv_fifo_data,
    output logic                  o_tx_valid,
    output logic                  o_tx_last,
    output logic [DATA_WIDTH-1:0] ov_tx_data,
    output logic [KEEP_WIDTH-1:0] ov_tx_keep,
    output logic                  o_tx_start,
    output logic [USER_WIDTH-1:0] ov_tx_user,
    input  logic                  i_tx_ready,
    output logic [31:0]           ov_pkt_cnt,
    output logic [31:0]           ov_drop_cnt
);
    localparam int BYTES = DATA_WIDTH/8;
    localparam int LEN_W = LEN_MSB - LEN_LSB + 1;

    typedef enum logic [1:0] {IDLE, TRANS, DRAIN} state_t;

    state_t                  state_q;
    logic [15:0]             bytes_left_q;
    logic [USER_WIDTH-1:0]   user_lat_q;
    logic                    first_q;
    logic                    valid_q;
    logic                    last_q;
    logic                    start_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [KEEP_WIDTH-1:0]   keep_q;
    logic [USER_WIDTH-1:0]   user_q;
    logic [31:0]             pkt_cnt_q;

    logic [LEN_W-1:0]        len4_d;
    logic                    pop_trans_d;
    logic                    is_last_d;
    logic [KEEP_WIDTH-1:0]   keep_d;

    // Length in 128 B units, rounded up.
    function automatic logic [USER_WIDTH-1:0] len4_to_user(input logic [LEN_W-1:0] l);
        logic [LEN_W:0] s;
        s = {1'b0, l} + (LEN_W+1)'(31);
        return USER_WIDTH'(s >> 5);
    endfunction

    function automatic logic [15:0] len4_to_bytes(input logic [LEN_W-1:0] l);
        return 16'(l) << 2;
    endfunction

    assign len4_d      = iv_fifo_data[LEN_MSB:LEN_LSB];
    assign pop_trans_d = (state_q == TRANS) && !i_fifo_empty && (!valid_q || i_tx_ready);
    assign is_last_d   = bytes_left_q <= 16'(BYTES);
    assign keep_d      = (bytes_left_q < 16'(BYTES)) ? bytes_left_q[KEEP_WIDTH-1:0] : '0;

`ifdef FIFO_TO_AXIS_LEN_CHECK_EN
    logic        pop_drain_d;
    logic        len_bad_d;
    logic [31:0] drop_cnt_q;

    assign pop_drain_d  = (state_q == DRAIN) && !i_fifo_empty;
    assign len_bad_d    = (len4_d == '0) || (int'(len4_d) > MAX_LEN4);
    assign o_fifo_rd_en = pop_trans_d || pop_drain_d;
    assign ov_drop_cnt  = drop_cnt_q;

    // Drain path pops the oversized/empty packet without touching the AXIS side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
        end else if (pop_drain_d && is_last_d) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end
`else
    assign o_fifo_rd_en = pop_trans_d;
    assign ov_drop_cnt  = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bytes_left_q <= '0;
            user_lat_q   <= '0;
            first_q      <= 1'b0;
            valid_q      <= 1'b0;
            last_q       <= 1'b0;
            start_q      <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
            user_q       <= '0;
            pkt_cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!i_fifo_empty) begin
                        first_q      <= 1'b1;
                        user_lat_q   <= len4_to_user(len4_d);
                        bytes_left_q <= len4_to_bytes(len4_d);
                        state_q      <= TRANS;
`ifdef FIFO_TO_AXIS_LEN_CHECK_EN
                        if (len_bad_d) begin
                            state_q <= DRAIN;
                            if (len4_d == '0) begin
                                bytes_left_q <= 16'd1;
                            end
                        end
`endif
                    end
                end
                TRANS: begin
                    if (pop_trans_d) begin
                        first_q      <= 1'b0;
                        bytes_left_q <= bytes_left_q - 16'(BYTES);
                        if (is_last_d) begin
                            state_q   <= IDLE;
                            pkt_cnt_q <= pkt_cnt_q + 32'd1;
                        end
                    end
                end
                DRAIN: begin
`ifdef FIFO_TO_AXIS_LEN_CHECK_EN
                    if (pop_drain_d) begin
                        bytes_left_q <= bytes_left_q - 16'(BYTES);
                        if (is_last_d) begin
                            state_q <= IDLE;
                        end
                    end
`else
                    state_q <= IDLE;
`endif
                end
                default: state_q <= IDLE;
            endcase

            // Output register: reload on pop, otherwise hold until accepted, then return to zero.
            if (pop_trans_d) begin
                valid_q <= 1'b1;
                data_q  <= iv_fifo_data;
                start_q <= first_q;
                last_q  <= is_last_d;
                keep_q  <= keep_d;
                user_q  <= user_lat_q;
            end else if (i_tx_ready) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                start_q <= 1'b0;
                last_q  <= 1'b0;
                keep_q  <= '0;
                user_q  <= '0;
            end
        end
    end

    assign o_tx_valid = valid_q;
    assign o_tx_last  = last_q;
    assign o_tx_start = start_q;
    assign ov_tx_data = data_q;
    assign ov_tx_keep = keep_q;
    assign ov_tx_user = user_q;
    assign ov_pkt_cnt = pkt_cnt_q;
endmodule
